// File: rtl/ws2812_rx.sv
`timescale 1ns/1ps
// ws2812_rx: decodes a WS2812-style single-wire LED stream into indexed 24-bit
// {B,R,G} pixels and reports the end of each frame on the line's reset gap.
module ws2812_rx #(
   parameter int T_MIN_HIGH = 2,
   parameter int T_THRESH   = 8,
   parameter int T_MAX_HIGH = 20,
   parameter int T_RESET    = 500,
   parameter int NUM_LEDS   = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        din,
   output logic [23:0] pixel_data,
   output logic        pixel_valid,
   output logic [7:0]  pixel_index,
   output logic        frame_done,
   output logic        frame_err,
   output logic [7:0]  led_count
);

   typedef enum logic [1:0] {SYNC, IDLE, HIGH} state_t;

   localparam logic [5:0]  MIN_HI   = 6'(T_MIN_HIGH);
   localparam logic [5:0]  THRESH   = 6'(T_THRESH);
   localparam logic [5:0]  MAX_HI   = 6'(T_MAX_HIGH);
   localparam logic [5:0]  HI_SAT   = 6'h3F;
   localparam logic [12:0] RESET_LO = 13'(T_RESET);
   localparam logic [12:0] LO_SAT   = 13'h1FFF;
   localparam logic [8:0]  LED_MAX  = 9'(NUM_LEDS);

   logic        s1_q, s2_q, s3_q;
   logic        rise, fall, gap;
   logic [5:0]  hi_cnt_q;
   logic [12:0] lo_cnt_q;
   state_t      state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [8:0]  pix_cnt_q, pix_cnt_d;
   logic [23:0] shreg_q, shreg_d, word;
   logic        err_q, err_d;
   logic [23:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic [7:0]  index_q, index_d;
   logic        done_q, done_d;
   logic        ferr_q, ferr_d;
   logic [7:0]  count_q, count_d;

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;
   // lo_cnt saturates far above T_RESET, so equality fires once per low stretch.
   assign gap  = (lo_cnt_q == RESET_LO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         s3_q     <= 1'b0;
         hi_cnt_q <= '0;
         lo_cnt_q <= '0;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (s2_q) begin
            lo_cnt_q <= '0;
            if (hi_cnt_q != HI_SAT) hi_cnt_q <= hi_cnt_q + 6'd1;
         end else begin
            hi_cnt_q <= '0;
            if (lo_cnt_q != LO_SAT) lo_cnt_q <= lo_cnt_q + 13'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= SYNC;
         bit_cnt_q <= '0;
         pix_cnt_q <= '0;
         shreg_q   <= '0;
         err_q     <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         pix_cnt_q <= pix_cnt_d;
         shreg_q   <= shreg_d;
         err_q     <= err_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         index_q   <= index_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      pix_cnt_d = pix_cnt_q;
      shreg_d   = shreg_q;
      err_d     = err_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      index_d   = index_q;
      done_d    = 1'b0;
      ferr_d    = 1'b0;
      count_d   = count_q;
      word      = shreg_q;
      word[bit_cnt_q] = (hi_cnt_q >= THRESH);

      // The gap is also honoured in SYNC so a stuck-high abort still gets reported.
      if (gap && (state_q != HIGH)) begin
         if ((bit_cnt_q != 5'd0) || err_q) begin
            ferr_d  = 1'b1;
            count_d = pix_cnt_q[7:0];
         end else if (pix_cnt_q != 9'd0) begin
            done_d  = 1'b1;
            count_d = pix_cnt_q[7:0];
         end
         pix_cnt_d = '0;
         bit_cnt_d = '0;
         err_d     = 1'b0;
      end

      case (state_q)
         SYNC: begin
            if (gap) state_d = rise ? HIGH : IDLE;
         end
         IDLE: begin
            if (rise) state_d = HIGH;
         end
         HIGH: begin
            if (fall) begin
               state_d = IDLE;
               if (hi_cnt_q < MIN_HI) begin
                  state_d = IDLE;
               end else if (hi_cnt_q > MAX_HI) begin
                  err_d = 1'b1;
               end else begin
                  shreg_d = word;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = '0;
                     if (pix_cnt_q == LED_MAX) begin
                        err_d = 1'b1;
                     end else begin
                        valid_d   = 1'b1;
                        data_d    = word;
                        index_d   = pix_cnt_q[7:0];
                        pix_cnt_d = pix_cnt_q + 9'd1;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 5'd1;
                  end
               end
            end else if (hi_cnt_q == HI_SAT) begin
               err_d   = 1'b1;
               state_d = SYNC;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   assign pixel_data  = data_q;
   assign pixel_valid = valid_q;
   assign pixel_index = index_q;
   assign frame_done  = done_q;
   assign frame_err   = ferr_q;
   assign led_count   = count_q;

endmodule
